node_send_sched: RTL and testbench
==================================

# node_send_sched

Round-robin send scheduler for one network node. It shares the node's single IF-to-router send port between up to NUM_REQ local result producers, such as PE add/mult result channels. It sequences the IF send handshake (`comm_send_req` → `comm_send_ack` → one-cycle `data_valid`) for each single-word packet and recovers from a missing ack with a timeout. It sits between the PE result sources and `m_if_2_router_v3` inside the node module.

## Interface
- NUM_REQ, 4, number of requesters (2..8); GW = $clog2(NUM_REQ)
- ACK_TIMEOUT, 255, maximum cycles spent in REQ waiting for ack (1..255)
- N_clk  in  1  clock, all state on rising edge
- N_rst  in  1  reset, asynchronous, active-high
- local_id  in  8  node id, driven onto o_src
- rq_valid  in  NUM_REQ  requester i has a word pending
- rq_dst  in  NUM_REQ*8  destination of requester i, slice [8i+7:8i]
- rq_data  in  NUM_REQ*32  payload of requester i, slice [32i+31:32i]
- rq_ready  out  NUM_REQ  one-hot pulse: word of requester i consumed
- o_comm_send_req  out  1  to IF i_comm_send_req
- i_comm_send_ack  in  1  from IF o_comm_send_ack
- o_data_valid  out  1  to IF i_data_valid
- o_data  out  32  to IF i_data
- o_src  out  8  to IF i_src
- o_dst  out  8  to IF i_dst
- o_grant  out  GW  index of the current or last granted requester
- o_busy  out  1  high in any state other than IDLE
- o_timeout  out  1  one-cycle pulse when a request is abandoned

## Operation
- FSM states: IDLE, REQ, SEND, GAP.
- **IDLE**
  - When any rq_valid bit is high, pick the first set bit searching upward from ptr (wrapping around).
  - Latch o_grant, o_data, o_dst from that requester, and latch o_src = local_id.
  - Clear the timeout counter and go to REQ.
- **REQ**
  - o_comm_send_req=1; the counter increments each cycle.
  - If i_comm_send_ack=1, go to SEND.
  - Otherwise, if counter == ACK_TIMEOUT-1: pulse o_timeout, set ptr = grant+1 mod NUM_REQ, go to GAP. The word is not consumed and rq_ready stays 0.
  - If ack arrives in the same cycle the timeout is reached, ack wins.
- **SEND**
  - o_comm_send_req=0, o_data_valid=1, and rq_ready[grant]=1 for exactly this cycle.
  - Set ptr = grant+1 mod NUM_REQ and go to GAP.
- **GAP**
  - All strobes low for one cycle, so the IF sees send_req deasserted between packets.
  - Go to IDLE.
- Payload, destination and source are captured at grant.
  - Changes to rq_data/rq_dst/local_id after grant are ignored.
  - If rq_valid drops after grant, the latched word is still sent and rq_ready still pulses.
- Requesters hold rq_valid, rq_data and rq_dst stable until they see rq_ready. A requester may present a new word in the cycle after rq_ready.
- o_data/o_src/o_dst/o_grant hold their values until the next grant.
- Wrap-around: ptr = NUM_REQ-1 advances to 0. With every rq_valid bit high, grants cycle 0,1,2,…,NUM_REQ-1,0.

## Timing
- Reset values: all outputs 0, state IDLE, ptr 0, counter 0. Reset takes effect immediately, mid-packet included, and drops o_comm_send_req and o_data_valid asynchronously.
- rq_valid high at edge T (state IDLE): o_busy=1 and o_comm_send_req=1 from T+1.
- Ack sampled high at edge A: o_data_valid and rq_ready pulse during cycle A+1 (SEND). GAP is at A+2, IDLE at A+3.
- Minimum packet period with an immediate ack: 4 cycles (IDLE, REQ, SEND, GAP).
- Timeout: with no ack, o_comm_send_req stays high for exactly ACK_TIMEOUT cycles. o_timeout pulses in the first GAP cycle.
- o_data_valid is never high in the same cycle as o_comm_send_req.
- At most one rq_ready bit is high per cycle.

## Test plan
- **Single requester, ack one cycle after req:** rq_valid[2]=1, rq_dst[2]=8'd4, rq_data[2]=32'h40200000, local_id=7 → one o_data_valid pulse with o_data=40200000, o_dst=4, o_src=7, o_grant=2, and rq_ready=4'b0100 in that cycle.
- **All four requesters valid, ack always returned:** grants 0,1,2,3,0 in order; successive o_data_valid pulses are exactly 4 cycles apart.
- **ACK_TIMEOUT=5, ack never asserted, only requester 1 valid:**
  - o_comm_send_req high for exactly 5 cycles, then o_timeout pulses, with no rq_ready.
  - Requester 1 is re-granted after the GAP.
- **Ack in the same cycle the count reaches ACK_TIMEOUT-1:** SEND occurs, no o_timeout.
- **N_rst asserted during REQ and during SEND:** all outputs 0 immediately and no rq_ready pulse. After release with rq_valid=4'b1000, the first grant is 3 (search starts from ptr=0).
- **Requester changes rq_data and drops rq_valid after grant, before ack:** the originally latched word is sent and rq_ready still pulses for it.

Source files
------------

// File: rtl/node_send_sched.sv
// Round-robin scheduler sharing the node's single IF send port among NUM_REQ
// result producers; sequences send_req/ack/data_valid with an ack timeout.
module node_send_sched #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned ACK_TIMEOUT = 255,
   localparam int unsigned GW         = $clog2(NUM_REQ)
) (
   input  logic                    N_clk,
   input  logic                    N_rst,
   input  logic [7:0]              local_id,
   input  logic [NUM_REQ-1:0]      rq_valid,
   input  logic [NUM_REQ*8-1:0]    rq_dst,
   input  logic [NUM_REQ*32-1:0]   rq_data,
   output logic [NUM_REQ-1:0]      rq_ready,
   output logic                    o_comm_send_req,
   input  logic                    i_comm_send_ack,
   output logic                    o_data_valid,
   output logic [31:0]             o_data,
   output logic [7:0]              o_src,
   output logic [7:0]              o_dst,
   output logic [GW-1:0]           o_grant,
   output logic                    o_busy,
   output logic                    o_timeout
);

   localparam int unsigned CW = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_SEND = 2'd2;
   localparam logic [1:0] ST_GAP  = 2'd3;

   logic [1:0]          state, state_nxt;
   logic [GW-1:0]       ptr, ptr_nxt;
   logic [CW-1:0]       cnt, cnt_nxt;

   logic [GW-1:0]       grant_nxt;
   logic [31:0]         data_nxt;
   logic [7:0]          src_nxt;
   logic [7:0]          dst_nxt;
   logic                req_nxt;
   logic                dv_nxt;
   logic [NUM_REQ-1:0]  ready_nxt;
   logic                to_nxt;
   logic                busy_nxt;

   logic                pick_found;
   logic [GW-1:0]       pick_idx;
   logic [GW-1:0]       scan_idx;
   logic [GW-1:0]       ptr_inc;

   // First pending requester at or above ptr, wrapping around
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      scan_idx   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan_idx = GW'((32'(ptr) + k) % NUM_REQ);
         if (!pick_found && rq_valid[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx;
         end
      end
   end

   assign ptr_inc = (o_grant == GW'(NUM_REQ - 1)) ? '0 : o_grant + GW'(1);

   // Next state and next registered output values
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      grant_nxt = o_grant;
      data_nxt  = o_data;
      src_nxt   = o_src;
      dst_nxt   = o_dst;
      req_nxt   = 1'b0;
      dv_nxt    = 1'b0;
      ready_nxt = '0;
      to_nxt    = 1'b0;

      case (state)
         ST_IDLE: begin
            if (pick_found) begin
               grant_nxt = pick_idx;
               data_nxt  = rq_data[32*pick_idx +: 32];
               dst_nxt   = rq_dst[8*pick_idx +: 8];
               src_nxt   = local_id;
               cnt_nxt   = '0;
               req_nxt   = 1'b1;
               state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            cnt_nxt = cnt + CW'(1);
            // Ack wins over a simultaneous timeout
            if (i_comm_send_ack) begin
               dv_nxt    = 1'b1;
               ready_nxt = NUM_REQ'(1) << o_grant;
               state_nxt = ST_SEND;
            end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
               to_nxt    = 1'b1;
               ptr_nxt   = ptr_inc;
               state_nxt = ST_GAP;
            end else begin
               req_nxt = 1'b1;
            end
         end
         ST_SEND: begin
            ptr_nxt   = ptr_inc;
            state_nxt = ST_GAP;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      busy_nxt = (state_nxt != ST_IDLE);
   end

   always_ff @(posedge N_clk or posedge N_rst) begin
      if (N_rst) begin
         state           <= ST_IDLE;
         ptr             <= '0;
         cnt             <= '0;
         o_grant         <= '0;
         o_data          <= '0;
         o_src           <= '0;
         o_dst           <= '0;
         o_comm_send_req <= 1'b0;
         o_data_valid    <= 1'b0;
         rq_ready        <= '0;
         o_timeout       <= 1'b0;
         o_busy          <= 1'b0;
      end else begin
         state           <= state_nxt;
         ptr             <= ptr_nxt;
         cnt             <= cnt_nxt;
         o_grant         <= grant_nxt;
         o_data          <= data_nxt;
         o_src           <= src_nxt;
         o_dst           <= dst_nxt;
         o_comm_send_req <= req_nxt;
         o_data_valid    <= dv_nxt;
         rq_ready        <= ready_nxt;
         o_timeout       <= to_nxt;
         o_busy          <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_node_send_sched.sv
// Directed bench for node_send_sched (NUM_REQ=4, ACK_TIMEOUT=5).
module tb_node_send_sched;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned GW      = 2;

   logic                  N_clk;
   logic                  N_rst;
   logic [7:0]            local_id;
   logic [NUM_REQ-1:0]    rq_valid;
   logic [NUM_REQ*8-1:0]  rq_dst;
   logic [NUM_REQ*32-1:0] rq_data;
   logic [NUM_REQ-1:0]    rq_ready;
   logic                  o_comm_send_req;
   logic                  i_comm_send_ack;
   logic                  o_data_valid;
   logic [31:0]           o_data;
   logic [7:0]            o_src;
   logic [7:0]            o_dst;
   logic [GW-1:0]         o_grant;
   logic                  o_busy;
   logic                  o_timeout;

   int  n_cmp;
   int  n_bad;
   int  cyc;
   logic auto_ack;

   node_send_sched #(.NUM_REQ(NUM_REQ), .ACK_TIMEOUT(5)) dut (
      .N_clk           (N_clk),
      .N_rst           (N_rst),
      .local_id        (local_id),
      .rq_valid        (rq_valid),
      .rq_dst          (rq_dst),
      .rq_data         (rq_data),
      .rq_ready        (rq_ready),
      .o_comm_send_req (o_comm_send_req),
      .i_comm_send_ack (i_comm_send_ack),
      .o_data_valid    (o_data_valid),
      .o_data          (o_data),
      .o_src           (o_src),
      .o_dst           (o_dst),
      .o_grant         (o_grant),
      .o_busy          (o_busy),
      .o_timeout       (o_timeout)
   );

   initial N_clk = 1'b0;
   always #5 N_clk = ~N_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Advance one cycle; optionally answer send_req like an always-ready IF
   task automatic tick();
      @(posedge N_clk);
      #1;
      cyc++;
      if (auto_ack) i_comm_send_ack = o_comm_send_req;
      check("req_dv_excl", 64'(o_data_valid & o_comm_send_req), 64'd0);
      check("ready_onehot", 64'($onehot0(rq_ready)), 64'd1);
   endtask

   task automatic drain();
      for (int c = 0; c < 20 && o_busy; c++) tick();
      check("drain_idle", 64'(o_busy), 64'd0);
   endtask

   int unsigned exp_g [5] = '{0, 1, 2, 3, 0};
   int pulses, last, nreq;
   logic to_seen;
   logic [NUM_REQ-1:0] rdy_acc;

   initial begin
      n_cmp = 0; n_bad = 0; cyc = 0;
      N_rst = 1'b1; auto_ack = 1'b0; i_comm_send_ack = 1'b0;
      rq_valid = '0; rq_dst = '0; rq_data = '0; local_id = 8'd0;

      // Reset state
      repeat (2) @(posedge N_clk);
      #1;
      check("rst_req", 64'(o_comm_send_req), 64'd0);
      check("rst_dv", 64'(o_data_valid), 64'd0);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_ready", 64'(rq_ready), 64'd0);
      check("rst_data", 64'(o_data), 64'd0);
      N_rst = 1'b0;
      tick();

      // Single requester, immediate ack
      local_id = 8'd7;
      rq_dst[23:16] = 8'd4;
      rq_data[95:64] = 32'h4020_0000;
      rq_valid = 4'b0100;
      auto_ack = 1'b1;
      tick();
      check("t1_req", 64'(o_comm_send_req), 64'd1);
      check("t1_busy", 64'(o_busy), 64'd1);
      tick();
      check("t1_dv", 64'(o_data_valid), 64'd1);
      check("t1_data", 64'(o_data), 64'h4020_0000);
      check("t1_dst", 64'(o_dst), 64'd4);
      check("t1_src", 64'(o_src), 64'd7);
      check("t1_grant", 64'(o_grant), 64'd2);
      check("t1_ready", 64'(rq_ready), 64'b0100);
      rq_valid = '0;
      tick();
      check("t1_gap_dv", 64'(o_data_valid), 64'd0);
      check("t1_gap_busy", 64'(o_busy), 64'd1);
      tick();
      check("t1_idle", 64'(o_busy), 64'd0);

      // All requesters valid: grants 0,1,2,3,0 every 4 cycles
      N_rst = 1'b1;
      #1;
      N_rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rq_data[32*i +: 32] = 32'hA0 + 32'(i);
         rq_dst[8*i +: 8]    = 8'd10 + 8'(i);
      end
      rq_valid = 4'b1111;
      pulses = 0; last = 0;
      for (int c = 0; c < 60 && pulses < 5; c++) begin
         tick();
         if (o_data_valid) begin
            check("rr_grant", 64'(o_grant), 64'(exp_g[pulses]));
            check("rr_data", 64'(o_data), 64'(32'hA0 + exp_g[pulses]));
            check("rr_dst", 64'(o_dst), 64'(8'd10 + 8'(exp_g[pulses])));
            check("rr_ready", 64'(rq_ready), 64'(4'b0001 << exp_g[pulses]));
            if (pulses > 0) check("rr_period", 64'(cyc - last), 64'd4);
            last = cyc;
            pulses++;
         end
      end
      check("rr_pulses", 64'(pulses), 64'd5);
      rq_valid = '0;
      drain();

      // Timeout with requester 1 only, no ack
      auto_ack = 1'b0;
      i_comm_send_ack = 1'b0;
      rq_valid = 4'b0010;
      nreq = 0; to_seen = 1'b0; rdy_acc = '0;
      for (int c = 0; c < 40 && !to_seen; c++) begin
         tick();
         if (o_comm_send_req) nreq++;
         rdy_acc |= rq_ready;
         if (o_timeout) to_seen = 1'b1;
      end
      check("to_seen", 64'(to_seen), 64'd1);
      check("to_req_cycles", 64'(nreq), 64'd5);
      check("to_no_ready", 64'(rdy_acc), 64'd0);
      check("to_gap_req", 64'(o_comm_send_req), 64'd0);
      check("to_gap_busy", 64'(o_busy), 64'd1);
      tick();
      check("to_pulse_end", 64'(o_timeout), 64'd0);
      check("to_idle", 64'(o_busy), 64'd0);
      tick();
      check("to_regrant_req", 64'(o_comm_send_req), 64'd1);
      check("to_regrant_id", 64'(o_grant), 64'd1);

      // Ack arrives in the last REQ cycle: ack wins
      repeat (4) tick();
      check("lim_req", 64'(o_comm_send_req), 64'd1);
      i_comm_send_ack = 1'b1;
      tick();
      check("lim_dv", 64'(o_data_valid), 64'd1);
      check("lim_no_to", 64'(o_timeout), 64'd0);
      check("lim_ready", 64'(rq_ready), 64'b0010);
      i_comm_send_ack = 1'b0;
      rq_valid = '0;
      tick();
      check("lim_gap_no_to", 64'(o_timeout), 64'd0);
      drain();

      // Reset during REQ and during SEND
      rq_data[31:0] = 32'hCAFE_0000;
      rq_valid = 4'b0001;
      tick();
      check("r5_req", 64'(o_comm_send_req), 64'd1);
      check("r5_grant", 64'(o_grant), 64'd0);
      N_rst = 1'b1;
      #1;
      check("r5_rst_req", 64'(o_comm_send_req), 64'd0);
      check("r5_rst_busy", 64'(o_busy), 64'd0);
      check("r5_rst_data", 64'(o_data), 64'd0);
      N_rst = 1'b0;
      tick();
      check("r5_req2", 64'(o_comm_send_req), 64'd1);
      i_comm_send_ack = 1'b1;
      tick();
      check("r5_send_dv", 64'(o_data_valid), 64'd1);
      N_rst = 1'b1;
      #1;
      check("r5_rst_dv", 64'(o_data_valid), 64'd0);
      check("r5_rst_ready", 64'(rq_ready), 64'd0);
      i_comm_send_ack = 1'b0;
      rq_valid = 4'b1000;
      rq_data[127:96] = 32'h0000_BEEF;
      tick();
      check("r5_hold_ready", 64'(rq_ready), 64'd0);
      check("r5_hold_busy", 64'(o_busy), 64'd0);
      N_rst = 1'b0;
      auto_ack = 1'b1;
      tick();
      check("r5_first_grant", 64'(o_grant), 64'd3);
      check("r5_first_req", 64'(o_comm_send_req), 64'd1);
      tick();
      check("r5_first_dv", 64'(o_data_valid), 64'd1);
      check("r5_first_data", 64'(o_data), 64'h0000_BEEF);
      check("r5_first_ready", 64'(rq_ready), 64'b1000);
      rq_valid = '0;
      drain();

      // Payload latched at grant despite later changes
      auto_ack = 1'b0;
      i_comm_send_ack = 1'b0;
      local_id = 8'd9;
      rq_data[31:0] = 32'h1111_1111;
      rq_dst[7:0] = 8'h21;
      rq_valid = 4'b0001;
      tick();
      check("lat_req", 64'(o_comm_send_req), 64'd1);
      rq_data[31:0] = 32'h2222_2222;
      rq_dst[7:0] = 8'h33;
      local_id = 8'd5;
      rq_valid = '0;
      tick();
      i_comm_send_ack = 1'b1;
      tick();
      check("lat_dv", 64'(o_data_valid), 64'd1);
      check("lat_data", 64'(o_data), 64'h1111_1111);
      check("lat_dst", 64'(o_dst), 64'h21);
      check("lat_src", 64'(o_src), 64'd9);
      check("lat_ready", 64'(rq_ready), 64'b0001);
      i_comm_send_ack = 1'b0;
      tick();
      check("lat_hold_data", 64'(o_data), 64'h1111_1111);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
